// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction fetch front end. A PC register issues one request per cycle
//   to a fixed-latency fetch sub-unit (response one cycle after the request).
//   Returned words are paired with their PC and stored in a small circular
//   queue that feeds decode. A credit check (queued + in-flight < DEPTH)
//   guarantees every response has a free slot, so no response is ever lost
//   to a full queue. A redirect flushes the queue and the in-flight request
//   and restarts fetch at redirect_pc on the following cycle.
//
// Parameters
//   DEPTH      queue entries (power of two, >= 2)
//   RESET_VEC  first fetch PC after reset
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   redirect, redirect_pc      branch/exception redirect and its target PC
//   sub_ready                  sub-unit can accept a request
//   sub_addr, sub_new_request  request PC and strobe to the sub-unit
//   sub_flush                  sub-unit flush (mirrors redirect)
//   sub_data_out/valid         instruction word returned by the sub-unit
//   dec_valid/ready            head-of-queue handshake toward decode
//   dec_instruction, dec_pc    head entry contents (registered storage only)
module fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_VEC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        sub_ready,
  output logic [31:0] sub_addr,
  output logic        sub_new_request,
  output logic        sub_flush,
  input  logic [31:0] sub_data_out,
  input  logic        sub_data_valid,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instruction,
  output logic [31:0] dec_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // Control state (reset)
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          inflight_q, inflight_d;

  // Data state (no reset)
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];

  logic [CW:0]   credit_sum;
  logic          req;
  logic          push;
  logic          pop;
  logic          full;

  // Request side: one outstanding request per slot still free in the queue.
  always_comb begin
    credit_sum = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    full       = ({1'b0, count_q} == DEPTH_C);
    req        = sub_ready & ~redirect & ~rst & (credit_sum < DEPTH_C);
    push       = sub_data_valid & inflight_q & ~redirect & ~rst;
    pop        = (count_q != '0) & dec_ready & ~redirect & ~rst;
  end

  assign sub_addr        = pc_q;
  assign sub_new_request = req;
  assign sub_flush       = redirect;

  assign dec_valid       = (count_q != '0);
  assign dec_instruction = instr_mem[rd_ptr_q];
  assign dec_pc          = pc_mem[rd_ptr_q];

  always_comb begin
    pc_d          = pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;

    if (redirect) begin
      // The queue and any response still in flight belong to the old path.
      pc_d       = redirect_pc;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      inflight_d = 1'b0;
    end else begin
      if (req) begin
        pc_d          = pc_q + 32'd4;
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Register stage: control state with reset priority over everything else
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_VEC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      inflight_q <= inflight_d;
    end
  end

  // Register stage: data path (in-flight PC and queue storage)
  always_ff @(posedge clk) begin
    inflight_pc_q <= inflight_pc_d;
    if (push) begin
      instr_mem[wr_ptr_q] <= sub_data_out;
      pc_mem[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  // Protocol checks: the credit scheme makes both of these impossible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full))
        else $error("fetch_queue: push into a full queue");
      assert (!(sub_data_valid && !inflight_q))
        else $error("fetch_queue: response with no request in flight (dropped)");
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int          DEPTH     = 4;
  localparam logic [31:0] RESET_VEC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        sub_ready;
  logic [31:0] sub_addr;
  logic        sub_new_request;
  logic        sub_flush;
  logic [31:0] sub_data_out;
  logic        sub_data_valid;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instruction;
  logic [31:0] dec_pc;

  fetch_queue #(.DEPTH(DEPTH), .RESET_VEC(RESET_VEC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .sub_ready      (sub_ready),
    .sub_addr       (sub_addr),
    .sub_new_request(sub_new_request),
    .sub_flush      (sub_flush),
    .sub_data_out   (sub_data_out),
    .sub_data_valid (sub_data_valid),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instruction(dec_instruction),
    .dec_pc         (dec_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: decode queue as a plain list of {pc, word}.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_ipc;
  bit          m_inf;

  // Sub-unit responder state: response exactly one cycle after a request.
  bit          prev_req;
  logic [31:0] prev_addr;

  int n_assert;
  int n_fail;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
  endtask

  // One clock cycle: drive inputs after the falling edge, sample outputs
  // 1 ns later, compare against the model, then advance the model.
  task automatic step(input bit r, input bit rd, input logic [31:0] rpc,
                      input bit sr, input bit dr, input bit chk);
    bit exp_req;
    @(negedge clk);
    rst            = r;
    redirect       = rd;
    redirect_pc    = rpc;
    sub_ready      = sr;
    dec_ready      = dr;
    sub_data_valid = prev_req;
    sub_data_out   = prev_req ? instr_of(prev_addr) : $urandom;
    #1;
    exp_req = sr && !rd && !r && ((mq.size() + int'(m_inf)) < DEPTH);
    if (chk) begin
      chk1 ("sub_new_request", sub_new_request, exp_req);
      chk32("sub_addr", sub_addr, m_pc);
      chk1 ("sub_flush", sub_flush, rd);
      chk1 ("dec_valid", dec_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk32("dec_pc", dec_pc, mq[0].pc);
        chk32("dec_instruction", dec_instruction, mq[0].ins);
      end
    end
    if (r) begin
      m_pc  = RESET_VEC;
      m_inf = 1'b0;
      mq.delete();
    end else if (rd) begin
      m_pc  = rpc;
      m_inf = 1'b0;
      mq.delete();
    end else begin
      if (dr && mq.size() != 0) void'(mq.pop_front());
      if (sub_data_valid && m_inf) mq.push_back('{m_ipc, sub_data_out});
      m_inf = exp_req;
      if (exp_req) begin
        m_ipc = m_pc;
        m_pc  = m_pc + 32'd4;
      end
    end
    prev_req  = (sub_new_request === 1'b1);
    prev_addr = sub_addr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nreq;
    logic [31:0] last_addr;
    logic [31:0] rpc;
    bit          r, rd, sr, dr;

    n_assert  = 0;
    n_fail    = 0;
    prev_req  = 1'b0;
    prev_addr = '0;
    m_pc      = RESET_VEC;
    m_ipc     = '0;
    m_inf     = 1'b0;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; sub_ready = 1'b0;
    dec_ready = 1'b0; sub_data_valid = 1'b0; sub_data_out = '0;

    // Reset state
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 1);
    chk32("rst_addr", sub_addr, 32'h8000_0000);
    chk1 ("rst_dec_valid", dec_valid, 1'b0);
    chk1 ("rst_no_req", sub_new_request, 1'b0);

    // Reset release with full throughput
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 1, 1, 1);
      if (i == 0) chk32("rel_addr0", sub_addr, 32'h8000_0000);
      if (i == 1) begin
        chk32("rel_addr1", sub_addr, 32'h8000_0004);
        chk1 ("rel_dvalid1", dec_valid, 1'b0);
      end
      if (i == 2) begin
        chk1 ("rel_dvalid2", dec_valid, 1'b1);
        chk32("rel_dpc2", dec_pc, 32'h8000_0000);
      end
      if (i == 5) chk32("rel_dpc5", dec_pc, 32'h8000_000C);
    end

    // Backpressure: exactly DEPTH requests, then ordered drain
    step(1, 0, 0, 1, 1, 1);
    nreq = 0;
    last_addr = '0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 0, 1);
      if (sub_new_request === 1'b1) begin
        nreq++;
        last_addr = sub_addr;
      end
    end
    chk32("bp_nreq", nreq, 32'd4);
    chk32("bp_last_addr", last_addr, 32'h8000_000C);
    chk1 ("bp_stalled", sub_new_request, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, 1);
      chk32("bp_drain_pc", dec_pc, 32'h8000_0000 + 32'(4 * i));
    end
    step(0, 0, 0, 0, 1, 1);
    chk1("bp_empty", dec_valid, 1'b0);

    // Simultaneous push and pop at count = DEPTH-1
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 1, 1);
    chk1("pp_no_req_at_credit", sub_new_request, 1'b0);
    step(0, 0, 0, 1, 1, 1);
    chk1("pp_req_after", sub_new_request, 1'b1);
    chk32("pp_head", dec_pc, 32'h8000_0004);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 1);

    // Redirect with 2 queued and 1 in flight
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 1);
    step(0, 1, 32'h0000_1000, 1, 1, 1);
    chk1("rd_flush", sub_flush, 1'b1);
    chk1("rd_no_req", sub_new_request, 1'b0);
    chk1("rd_resp_arrives", sub_data_valid, 1'b1);
    step(0, 0, 0, 1, 1, 1);
    chk1 ("rd_dvalid", dec_valid, 1'b0);
    chk32("rd_addr", sub_addr, 32'h0000_1000);
    chk1 ("rd_req", sub_new_request, 1'b1);
    step(0, 0, 0, 1, 1, 1);
    chk1("rd_dvalid_still0", dec_valid, 1'b0);
    step(0, 0, 0, 1, 1, 1);
    chk32("rd_first_pc", dec_pc, 32'h0000_1000);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 1);

    // Reset with a full queue
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0, 1);
    chk1("full_dvalid", dec_valid, 1'b1);
    step(1, 0, 0, 1, 1, 1);
    step(0, 0, 0, 1, 0, 1);
    chk1 ("frst_dvalid", dec_valid, 1'b0);
    chk32("frst_addr", sub_addr, 32'h8000_0000);
    // Reset while a response is arriving: it must be discarded
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    chk1("rrst_resp_arrives", sub_data_valid, 1'b1);
    step(0, 0, 0, 0, 0, 1);
    chk1("rrst_dvalid", dec_valid, 1'b0);
    step(0, 0, 0, 0, 0, 1);
    chk1("rrst_dvalid2", dec_valid, 1'b0);

    // PC wrap
    step(0, 1, 32'hFFFF_FFFC, 1, 1, 1);
    step(0, 0, 0, 1, 1, 1);
    chk32("wrap_addr0", sub_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 1, 1, 1);
    chk32("wrap_addr1", sub_addr, 32'h0000_0000);
    step(0, 0, 0, 1, 1, 1);
    chk32("wrap_dpc0", dec_pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 1, 1, 1);
    chk32("wrap_dpc1", dec_pc, 32'h0000_0000);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 49) == 0);
      rd  = ($urandom_range(0, 19) == 0);
      sr  = ($urandom_range(0, 3) != 0);
      dr  = ($urandom_range(0, 1) != 0);
      rpc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0;
      step(r, rd, rpc, sr, dr, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
